truth_table_sweeper: RTL and testbench

- Self-checking stimulus engine for the lab's combinational gate-level and operator exercises.
- Replaces hand-written `#1` input sweeps: on `start` it walks every one of 2^N_IN input combinations in binary order and drives each onto the device under test (DUT).
- After each vector it waits a programmable settle interval, samples the DUT outputs and compares them against an expected truth table supplied as a parameter.
- Reports a mismatch count, pass/fail and the first failing vector, usable both in simulation and on the FPGA, where outputs drive LEDs.

---
 rtl/truth_table_sweeper_pkg.sv | 24 ++
 rtl/truth_table_sweeper_settle_timer.sv | 34 +++
 rtl/truth_table_sweeper.sv | 156 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and counter sizing.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package truth_table_sweeper_pkg;

  // Sweep controller states; the encodings are fixed so they can be probed or shown on LEDs.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width needed to hold the values 0..n-1, with a floor of one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: loadable down-counter that paces how long each stimulus vector is held.
// Latency: zero is combinational from the count; a load takes effect on the next edge.
// Backpressure: none; the counter parks at zero until the next load.
module settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic zero
);

  localparam int CNT_W = cnt_width(SETTLE);
  // The count runs SETTLE-1 down to 0, so the vector is held SETTLE cycles in APPLY.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] count;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks all 2^N_IN input vectors, samples the DUT after SETTLE cycles, scores vs EXPECTED.
// Latency: first vector 1 cycle after start; SETTLE+1 cycles per vector; done (2^N_IN)*(SETTLE+1)+1 cycles after start.
// Backpressure: start is ignored while a sweep is running (not queued). SWEEP_STOP_ON_FAIL_EN ends the sweep on the first mismatch.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 2,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  // Every vector can mismatch at most once, so 2^N_IN is the ceiling of the error count.
  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  state_t state_q;
  state_t state_d;

  logic             timer_load;
  logic             timer_zero;
  logic             sweep_begin;
  logic             vec_inc;
  logic             cmp_en;
  logic             finish;
  logic             mismatch;
  logic             last_vec;
  logic [N_OUT-1:0] exp_slice;

  settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .zero (timer_zero)
  );

  // Comparator against the expected row for the vector currently applied.
  always_comb begin
    exp_slice = EXPECTED[int'(dut_in) * N_OUT +: N_OUT];
    mismatch  = (dut_out != exp_slice);
    last_vec  = &dut_in;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sweep ends on the all-ones vector, or on the first mismatch when stopping on fail.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (timer_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (last_vec || (STOP_ON_FAIL && mismatch)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: control strobes for the vector counter, timer and result registers.
  always_comb begin
    sweep_begin = (state_q == ST_IDLE) && start;
    cmp_en      = (state_q == ST_CHECK);
    vec_inc     = cmp_en && (state_d == ST_APPLY);
    timer_load  = sweep_begin || vec_inc;
    finish      = (state_q == ST_DONE);
  end

  // Vector counter and result registers; results hold in IDLE so they stay readable after a sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;

      if (sweep_begin) begin
        dut_in     <= '0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        pass       <= 1'b0;
        busy       <= 1'b1;
      end

      if (cmp_en && mismatch) begin
        if (err_count != ERR_MAX) begin
          err_count <= err_count + 1'b1;
        end
        if (!fail_valid) begin
          fail_vec   <= dut_in;
          fail_valid <= 1'b1;
        end
      end

      // dut_in only advances from CHECK toward APPLY, so it never wraps past all-ones.
      if (vec_inc) begin
        dut_in <= dut_in + 1'b1;
      end

      // err_count already includes any mismatch on the final vector by the time DONE is reached.
      if (finish) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == '0);
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three sweepers (3-in good table, 3-in corrupted table, 4-in SETTLE=1)
// driven by shared random start/reset, checked every cycle against a timeline model of the sweep.
module tb_truth_table_sweeper;

  // Reference DUTs: y1 = A&B|C, y2 = A^B^C with A the MSB.
  function automatic logic [1:0] f3(input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    return {a ^ b ^ c, (a & b) | c};
  endfunction

  function automatic logic [1:0] f4(input logic [3:0] v);
    return {v[3] | ~v[0], (v[3] & v[2]) | (v[1] ^ v[0])};
  endfunction

  function automatic logic [15:0] tab3(input bit corrupt);
    logic [15:0] t;
    logic [1:0]  s;
    t = '0;
    for (int v = 0; v < 8; v++) begin
      s = f3(3'(v));
      if (corrupt && (v == 5 || v == 6)) s = ~s;
      t[v*2 +: 2] = s;
    end
    return t;
  endfunction

  function automatic logic [31:0] tab4(input bit corrupt);
    logic [31:0] t;
    logic [1:0]  s;
    t = '0;
    for (int v = 0; v < 16; v++) begin
      s = f4(4'(v));
      if (corrupt) s = ~s;
      t[v*2 +: 2] = s;
    end
    return t;
  endfunction

  localparam logic [15:0] TAB_GOOD = tab3(1'b0);
  localparam logic [15:0] TAB_BAD  = tab3(1'b1);
  localparam logic [31:0] TAB_4    = tab4(1'b0);

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam int BAD_DONE = 19;
  localparam int BAD_ERR  = 1;
`else
  localparam int BAD_DONE = 25;
  localparam int BAD_ERR  = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic [2:0] g_in, b_in, g_fvec, b_fvec;
  logic [3:0] m_in, m_fvec, g_err, b_err;
  logic [4:0] m_err;
  logic [1:0] g_out, b_out, m_out;
  logic [2:0] busy_v, done_v, pass_v, fv_v;

  assign g_out = f3(g_in);
  assign b_out = f3(b_in);
  assign m_out = f4(m_in);

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(2), .EXPECTED(TAB_GOOD)) u_good (
    .clk(clk), .reset(reset), .start(start), .dut_in(g_in), .dut_out(g_out),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(g_err),
    .fail_valid(fv_v[0]), .fail_vec(g_fvec)
  );

  truth_table_sweeper #(.N_IN(3), .N_OUT(2), .SETTLE(2), .EXPECTED(TAB_BAD)) u_bad (
    .clk(clk), .reset(reset), .start(start), .dut_in(b_in), .dut_out(b_out),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(b_err),
    .fail_valid(fv_v[1]), .fail_vec(b_fvec)
  );

  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .SETTLE(1), .EXPECTED(TAB_4)) u_min (
    .clk(clk), .reset(reset), .start(start), .dut_in(m_in), .dut_out(m_out),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(m_err),
    .fail_valid(fv_v[2]), .fail_vec(m_fvec)
  );

  logic [3:0] a_in[3];
  logic [4:0] a_err[3];
  logic [3:0] a_fvec[3];
  assign a_in[0]   = {1'b0, g_in};
  assign a_in[1]   = {1'b0, b_in};
  assign a_in[2]   = m_in;
  assign a_err[0]  = {1'b0, g_err};
  assign a_err[1]  = {1'b0, b_err};
  assign a_err[2]  = m_err;
  assign a_fvec[0] = {1'b0, g_fvec};
  assign a_fvec[1] = {1'b0, b_fvec};
  assign a_fvec[2] = m_fvec;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Model configuration and per-vector mismatch map, derived from the bench's own tables.
  int nin[3]    = '{3, 3, 4};
  int settle[3] = '{2, 2, 1};
  bit mism[3][16];
  int k[3]      = '{-1, -1, -1};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Last vector visited: all-ones, or the first mismatch when stopping on fail.
  function automatic int last_vec(input int id);
    int l;
    l = (1 << nin[id]) - 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
    for (int v = (1 << nin[id]) - 1; v >= 0; v--) begin
      if (mism[id][v]) l = v;
    end
`endif
    return l;
  endfunction

  function automatic int t_end(input int id);
    return (last_vec(id) + 1) * (settle[id] + 1);
  endfunction

  // Expected outputs kk cycles after the start edge (kk < 0: nothing since reset).
  task automatic model(input int id, input int kk,
                       output int e_in, output int e_err, output int e_busy, output int e_done,
                       output int e_pass, output int e_fv, output int e_fvec);
    int per, l, te, kc, cnt, first;
    e_in = 0; e_err = 0; e_busy = 0; e_done = 0; e_pass = 0; e_fv = 0; e_fvec = 0;
    if (kk >= 0) begin
      per   = settle[id] + 1;
      l     = last_vec(id);
      te    = t_end(id);
      kc    = (kk > te) ? te : kk;
      cnt   = 0;
      first = -1;
      for (int v = 0; v <= l; v++) begin
        if (mism[id][v] && (v + 1) * per <= kc) begin
          cnt++;
          if (first < 0) first = v;
        end
      end
      e_in   = (kc / per > l) ? l : kc / per;
      e_err  = cnt;
      e_fv   = (first >= 0) ? 1 : 0;
      e_fvec = (first >= 0) ? first : 0;
      e_busy = (kk <= te) ? 1 : 0;
      e_done = (kk == te + 1) ? 1 : 0;
      e_pass = (kk > te && cnt == 0) ? 1 : 0;
    end
  endtask

  // Advance each model timeline on the clock edge using the same start/reset the DUTs sample.
  always @(posedge clk) begin
    for (int id = 0; id < 3; id++) begin
      if (reset) k[id] = -1;
      else if (start && (k[id] < 0 || k[id] >= t_end(id) + 1)) k[id] = 0;
      else if (k[id] >= 0 && k[id] < 1000000) k[id] = k[id] + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int e_in, e_err, e_busy, e_done, e_pass, e_fv, e_fvec;
    if (chk_on) begin
      for (int id = 0; id < 3; id++) begin
        model(id, k[id], e_in, e_err, e_busy, e_done, e_pass, e_fv, e_fvec);
        chk($sformatf("dut_in[%0d]", id), int'(a_in[id]), e_in);
        chk($sformatf("err_count[%0d]", id), int'(a_err[id]), e_err);
        chk($sformatf("busy[%0d]", id), int'(busy_v[id]), e_busy);
        chk($sformatf("done[%0d]", id), int'(done_v[id]), e_done);
        chk($sformatf("pass[%0d]", id), int'(pass_v[id]), e_pass);
        chk($sformatf("fail_valid[%0d]", id), int'(fv_v[id]), e_fv);
        if (e_fv != 0) chk($sformatf("fail_vec[%0d]", id), int'(a_fvec[id]), e_fvec);
      end
    end
  end

  initial begin
    logic [15:0] tg, tb;
    logic [31:0] t4;
    int dc[3];
    int ndone[3];
    int w;

    tg = TAB_GOOD;
    tb = TAB_BAD;
    t4 = TAB_4;
    for (int v = 0; v < 16; v++) begin
      mism[0][v] = (v < 8) && (f3(3'(v)) != tg[v*2 +: 2]);
      mism[1][v] = (v < 8) && (f3(3'(v)) != tb[v*2 +: 2]);
      mism[2][v] = (f4(4'(v)) != t4[v*2 +: 2]);
    end

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_busy", int'(busy_v), 0);
    chk("reset_err", int'(g_err), 0);
    reset = 1'b0;

    // Full sweep on all three, with start re-pulsed while busy.
    dc    = '{-1, -1, -1};
    ndone = '{0, 0, 0};
    start = 1'b1;
    @(negedge clk);
    for (int n = 0; n <= 40; n++) begin
      for (int id = 0; id < 3; id++) begin
        if (done_v[id]) begin
          ndone[id]++;
          if (dc[id] < 0) dc[id] = n;
        end
      end
      start = (n == 7 || n == 15);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_cycle_good", dc[0], 25);
    chk("done_cycle_bad", dc[1], BAD_DONE);
    chk("done_cycle_min", dc[2], 33);
    chk("single_sweep_good", ndone[0], 1);
    chk("single_sweep_min", ndone[2], 1);
    chk("good_pass", int'(pass_v[0]), 1);
    chk("good_err", int'(g_err), 0);
    chk("good_fail_valid", int'(fv_v[0]), 0);
    chk("bad_err", int'(b_err), BAD_ERR);
    chk("bad_fail_vec", int'(b_fvec), 5);
    chk("bad_fail_valid", int'(fv_v[1]), 1);
    chk("bad_pass", int'(pass_v[1]), 0);
    chk("min_last_vec", int'(m_in), 15);
    chk("min_pass", int'(pass_v[2]), 1);

    // Reset while the 3-input sweep is on vector 4.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (g_in != 3'd4 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("reach_vec4", int'(g_in), 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_dut_in", int'(g_in), 0);
    chk("rst_busy", int'(busy_v), 0);
    chk("rst_done", int'(done_v), 0);
    chk("rst_pass", int'(pass_v), 0);
    chk("rst_fail_valid", int'(fv_v), 0);
    chk("rst_err_min", int'(m_err), 0);

    // Clean sweep after the abort.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_good_pass", int'(pass_v[0]), 1);
    chk("post_rst_bad_err", int'(b_err), BAD_ERR);

    // start held high: back-to-back sweeps retrigger from IDLE.
    start = 1'b1;
    repeat (120) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // Random start/reset traffic.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
